// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//   Boot and patch controller for an instruction memory. While the core is
//   held (LOAD), an external loader streams words into IMEM. Once the core
//   runs, a loader request freezes the pipeline for one cycle, streams the
//   patch (PATCH), then releases the core with a one-cycle flush (RESUME).
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   i_ld_valid/addr/data/last   loader word offer (byte address)
//   o_ld_ready                  loader word accepted this cycle
//   i_fetch_pc, i_pipe_stall    fetch PC (read address) and hazard stall
//   o_fetch_en                  fetch-stage PC enable
//   o_core_hold                 holds the core pipeline idle
//   o_flush                     one-cycle flush pulse after a patch
//   o_mem_addr/wr_en/wr_data    instruction memory port
//   o_word_count                accepted words since reset (saturating)
//   o_err                       sticky bad-address flag
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_pipe_stall,
    output logic        o_fetch_en,
    output logic        o_core_hold,
    output logic        o_flush,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    output logic [15:0] o_word_count,
    output logic        o_err
);

    // Byte-address limit, widened so large depths cannot overflow 32 bits.
    localparam logic [33:0] ADDR_LIMIT = 34'(IMEM_DEPTH) << 2;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        FREEZE = 3'd3,
        PATCH  = 3'd4,
        RESUME = 3'd5
    } state_t;

    state_t state, state_next;

    logic accept;
    logic addr_ok;
    logic do_write;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign o_ld_ready = (state == LOAD) || (state == PATCH);
    assign accept     = i_ld_valid && o_ld_ready;
    assign addr_ok    = (i_ld_addr[1:0] == 2'b00) && ({2'b00, i_ld_addr} < ADDR_LIMIT);
    // The reset term keeps the write strobe low while rst is high even though
    // the state already reads LOAD and the loader may still be offering.
    assign do_write   = accept && addr_ok && !rst;

    assign o_mem_wr_en   = do_write;
    assign o_mem_addr    = do_write ? i_ld_addr : i_fetch_pc;
    assign o_mem_wr_data = i_ld_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            o_word_count <= 16'd0;
            o_err        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                o_word_count <= sat_inc(o_word_count);
                if (!addr_ok) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        o_core_hold = 1'b1;
        o_fetch_en  = 1'b0;
        o_flush     = 1'b0;
        case (state)
            LOAD: begin
                if (accept && i_ld_last) state_next = START;
            end
            START: begin
                state_next = RUN;
            end
            RUN: begin
                o_core_hold = 1'b0;
                o_fetch_en  = !i_pipe_stall;
                // A loader request wins over any stall.
                if (i_ld_valid) state_next = FREEZE;
            end
            FREEZE: begin
                state_next = PATCH;
            end
            PATCH: begin
                if (accept && i_ld_last) state_next = RESUME;
            end
            RESUME: begin
                o_core_hold = 1'b0;
                o_flush     = 1'b1;
                state_next  = RUN;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    logic        clk;
    logic        rst;
    logic        i_ld_valid;
    logic [31:0] i_ld_addr;
    logic [31:0] i_ld_data;
    logic        i_ld_last;
    logic        o_ld_ready;
    logic [31:0] i_fetch_pc;
    logic        i_pipe_stall;
    logic        o_fetch_en;
    logic        o_core_hold;
    logic        o_flush;
    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_data;
    logic [15:0] o_word_count;
    logic        o_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    imem_load_ctrl #(.IMEM_DEPTH(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ld_valid   (i_ld_valid),
        .i_ld_addr    (i_ld_addr),
        .i_ld_data    (i_ld_data),
        .i_ld_last    (i_ld_last),
        .o_ld_ready   (o_ld_ready),
        .i_fetch_pc   (i_fetch_pc),
        .i_pipe_stall (i_pipe_stall),
        .o_fetch_en   (o_fetch_en),
        .o_core_hold  (o_core_hold),
        .o_flush      (o_flush),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_wr_data(o_mem_wr_data),
        .o_word_count (o_word_count),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
        i_ld_valid = v;
        i_ld_addr  = a;
        i_ld_data  = d;
        i_ld_last  = l;
    endtask

    task automatic do_reset();
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        i_pipe_stall = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // Clock first rises at t=5; checks here happen before any edge.
        rst = 1'b1;
        offer(1'b1, 32'h0, 32'h1234, 1'b0);
        i_fetch_pc = 32'h100;
        i_pipe_stall = 1'b0;
        #2;
        total_cnt++; if (o_ld_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL rst_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL rst_fetch_en got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL rst_flush got %b want 0", o_flush); else pass_cnt++;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd0) $display("FAIL rst_count got %h want 0", o_word_count); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0) $display("FAIL rst_err got %b want 0", o_err); else pass_cnt++;
        // Reset held across edges with a word offered: nothing counts.
        step();
        step();
        total_cnt++; if (o_word_count !== 16'd0) $display("FAIL rst_hold_count got %h want 0", o_word_count); else pass_cnt++;
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        // Deasserted but no edge yet: still the reset values.
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL rst_release_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_ld_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", o_ld_ready); else pass_cnt++;
    endtask

    task automatic test_boot();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        datas = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
        do_reset();
        i_fetch_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, addrs[i], datas[i], (i == 2));
            #1;
            total_cnt++; if (o_mem_wr_en !== 1'b1) $display("FAIL boot_wr_en[%0d] got %b want 1", i, o_mem_wr_en); else pass_cnt++;
            total_cnt++; if (o_mem_addr !== addrs[i]) $display("FAIL boot_addr[%0d] got %h want %h", i, o_mem_addr, addrs[i]); else pass_cnt++;
            total_cnt++; if (o_mem_wr_data !== datas[i]) $display("FAIL boot_data[%0d] got %h want %h", i, o_mem_wr_data, datas[i]); else pass_cnt++;
            step();
        end
        // START
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL start_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL start_fetch_en got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_ld_ready !== 1'b0) $display("FAIL start_ready got %b want 0", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 32'h200) $display("FAIL start_addr got %h want 200", o_mem_addr); else pass_cnt++;
        step();
        // RUN
        total_cnt++; if (o_fetch_en !== 1'b1) $display("FAIL run_fetch_en got %b want 1", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b0) $display("FAIL run_hold got %b want 0", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd3) $display("FAIL boot_count got %0d want 3", o_word_count); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0) $display("FAIL boot_err got %b want 0", o_err); else pass_cnt++;
    endtask

    task automatic test_stall();
        // Continues in RUN from test_boot.
        i_pipe_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_fetch_pc = 32'h24 + 32'(4 * i);
            #1;
            total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL stall_fetch_en[%0d] got %b want 0", i, o_fetch_en); else pass_cnt++;
            total_cnt++; if (o_mem_addr !== 32'h24 + 32'(4 * i)) $display("FAIL stall_addr[%0d] got %h want %h", i, o_mem_addr, 32'h24 + 32'(4 * i)); else pass_cnt++;
            total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL stall_wr_en[%0d] got %b want 0", i, o_mem_wr_en); else pass_cnt++;
            step();
        end
        i_pipe_stall = 1'b0;
        #1;
        total_cnt++; if (o_fetch_en !== 1'b1) $display("FAIL unstall_fetch_en got %b want 1", o_fetch_en); else pass_cnt++;
    endtask

    task automatic test_patch();
        // Continues in RUN, word count 3.
        i_pipe_stall = 1'b1;
        i_fetch_pc = 32'h40;
        offer(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
        #1;
        total_cnt++; if (o_ld_ready !== 1'b0) $display("FAIL run_ready got %b want 0", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL run_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        step();
        // FREEZE
        total_cnt++; if (o_ld_ready !== 1'b0) $display("FAIL freeze_ready got %b want 0", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL freeze_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL freeze_fetch_en got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL freeze_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        step();
        // PATCH
        total_cnt++; if (o_ld_ready !== 1'b1) $display("FAIL patch_ready got %b want 1", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_mem_wr_en !== 1'b1) $display("FAIL patch_wr_en got %b want 1", o_mem_wr_en); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 32'h10) $display("FAIL patch_addr got %h want 10", o_mem_addr); else pass_cnt++;
        total_cnt++; if (o_mem_wr_data !== 32'hDEAD_BEEF) $display("FAIL patch_data got %h want deadbeef", o_mem_wr_data); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL patch_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL patch_flush got %b want 0", o_flush); else pass_cnt++;
        step();
        // RESUME
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++; if (o_flush !== 1'b1) $display("FAIL resume_flush got %b want 1", o_flush); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL resume_fetch_en got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b0) $display("FAIL resume_hold got %b want 0", o_core_hold); else pass_cnt++;
        step();
        // RUN again, stall still high
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL post_flush got %b want 0", o_flush); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL post_fetch_en_stall got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd4) $display("FAIL patch_count got %0d want 4", o_word_count); else pass_cnt++;
        i_pipe_stall = 1'b0;
        #1;
        total_cnt++; if (o_fetch_en !== 1'b1) $display("FAIL post_fetch_en got %b want 1", o_fetch_en); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        // Continues in RUN; enter PATCH with a non-last burst.
        offer(1'b1, 32'h14, 32'h5555_AAAA, 1'b0);
        step();
        step();
        total_cnt++; if (o_mem_wr_en !== 1'b1) $display("FAIL arst_pre_wr_en got %b want 1", o_mem_wr_en); else pass_cnt++;
        #1;
        rst = 1'b1;
        #1;
        total_cnt++; if (o_ld_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", o_ld_ready); else pass_cnt++;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL arst_hold got %b want 1", o_core_hold); else pass_cnt++;
        total_cnt++; if (o_fetch_en !== 1'b0) $display("FAIL arst_fetch_en got %b want 0", o_fetch_en); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL arst_flush got %b want 0", o_flush); else pass_cnt++;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL arst_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd0) $display("FAIL arst_count got %0d want 0", o_word_count); else pass_cnt++;
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        total_cnt++; if (o_core_hold !== 1'b1) $display("FAIL arst_release_hold got %b want 1", o_core_hold); else pass_cnt++;
    endtask

    task automatic test_bad_addr();
        do_reset();
        i_fetch_pc = 32'h300;
        offer(1'b1, 32'h6, 32'h1111_1111, 1'b0);
        #1;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL bad6_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 32'h300) $display("FAIL bad6_addr got %h want 300", o_mem_addr); else pass_cnt++;
        total_cnt++; if (o_err !== 1'b0) $display("FAIL bad6_err_same got %b want 0", o_err); else pass_cnt++;
        step();
        total_cnt++; if (o_err !== 1'b1) $display("FAIL bad6_err_next got %b want 1", o_err); else pass_cnt++;
        offer(1'b1, 32'h1000, 32'h2222_2222, 1'b0);
        #1;
        total_cnt++; if (o_mem_wr_en !== 1'b0) $display("FAIL bad1000_wr_en got %b want 0", o_mem_wr_en); else pass_cnt++;
        step();
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++; if (o_err !== 1'b1) $display("FAIL bad_err_sticky got %b want 1", o_err); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd2) $display("FAIL bad_count got %0d want 2", o_word_count); else pass_cnt++;
        // Highest legal word address still writes; err stays set.
        offer(1'b1, 32'hFFC, 32'h3333_3333, 1'b0);
        #1;
        total_cnt++; if (o_mem_wr_en !== 1'b1) $display("FAIL top_wr_en got %b want 1", o_mem_wr_en); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 32'hFFC) $display("FAIL top_addr got %h want ffc", o_mem_addr); else pass_cnt++;
        step();
        offer(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++; if (o_err !== 1'b1) $display("FAIL err_after_good got %b want 1", o_err); else pass_cnt++;
        total_cnt++; if (o_word_count !== 16'd3) $display("FAIL bad_count3 got %0d want 3", o_word_count); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        offer(1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 65534; i++) step();
        total_cnt++; if (o_word_count !== 16'hFFFE) $display("FAIL sat_fffe got %h want fffe", o_word_count); else pass_cnt++;
        step();
        total_cnt++; if (o_word_count !== 16'hFFFF) $display("FAIL sat_ffff got %h want ffff", o_word_count); else pass_cnt++;
        step();
        step();
        total_cnt++; if (o_word_count !== 16'hFFFF) $display("FAIL sat_nowrap got %h want ffff", o_word_count); else pass_cnt++;
        offer(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_patch();
        test_async_reset();
        test_bad_addr();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
